// File: rtl/iir_out_fifo.sv
// First-word-fall-through output buffer behind the IIR stage. It accepts every valid
// sample, drops samples when full and flags each drop in a sticky overflow bit.
module iir_out_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          vin,
  output logic [DW-1:0] dout,
  output logic          vout,
  input  logic          rdy,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  input  logic          clr_ovf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign vout  = !empty;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
  assign ovf   = ovf_q;

  always_comb begin
    pop      = vout && rdy;
    // A pop in the same cycle frees a slot for a push into a full FIFO.
    push     = vin && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    // A new drop takes priority over a clear in the same cycle.
    if (vin && full && !pop) ovf_d = 1'b1;
    else if (clr_ovf)        ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_iir_out_fifo.sv
// Directed and scoreboarded checks for iir_out_fifo: reset, FWFT latency, fill/drain,
// overflow and its clear, push+pop when full, and a long wrap run with random ready.
module tb_iir_out_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] din;
  logic       vin;
  logic [8:0] dout;
  logic       vout;
  logic       rdy;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       clr_ovf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  iir_out_fifo #(.DW(9), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .dout(dout), .vout(vout),
    .rdy(rdy), .count(count), .full(full), .empty(empty), .ovf(ovf),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, clock once, return at the next falling edge.
  task automatic step(input logic v, input logic [8:0] d, input logic r, input logic c);
    vin = v; din = d; rdy = r; clr_ovf = c;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0; rdy = 1'b0; clr_ovf = 1'b0; din = '0;
  endtask

  task automatic push_n(input int unsigned n, input int unsigned base);
    for (int unsigned i = 0; i < n; i++) step(1'b1, 9'(base + i), 1'b0, 1'b0);
  endtask

  logic [8:0]  q[$];
  logic        m_ovf;
  logic        m_pop, m_push, r;
  logic [8:0]  smp;

  initial begin
    rst = 1'b1; vin = 1'b0; din = '0; rdy = 1'b0; clr_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    check_val("rst_count", 32'(count), 0);
    check_val("rst_empty", 32'(empty), 1);
    check_val("rst_full",  32'(full),  0);
    check_val("rst_vout",  32'(vout),  0);
    check_val("rst_dout",  32'(dout),  0);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset mid-stream with 5 entries
    push_n(5, 9'h021);
    check_val("t1_pre_count", 32'(count), 5);
    check_val("t1_pre_dout",  32'(dout),  9'h021);
    rst = 1'b1;
    #1;
    check_val("t1_count", 32'(count), 0);
    check_val("t1_vout",  32'(vout),  0);
    check_val("t1_dout",  32'(dout),  0);
    check_val("t1_ovf",   32'(ovf),   0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2: single sample, FWFT latency
    step(1'b1, 9'h1A3, 1'b1, 1'b0);
    check_val("t2_vout", 32'(vout), 1);
    check_val("t2_dout", 32'(dout), 9'h1A3);
    step(1'b0, '0, 1'b1, 1'b0);
    check_val("t2_empty", 32'(empty), 1);
    check_val("t2_dout0", 32'(dout),  0);

    // 3: fill with 1..8 then drain in order
    push_n(8, 1);
    check_val("t3_full",  32'(full),  1);
    check_val("t3_count", 32'(count), 8);
    check_val("t3_empty", 32'(empty), 0);
    for (int unsigned i = 1; i <= 8; i++) begin
      check_val("t3_drain", 32'(dout), i);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check_val("t3_empty_end", 32'(empty), 1);
    check_val("t3_full_end",  32'(full),  0);

    // 4: overflow, clear, and set-wins-over-clear
    push_n(8, 9'h011);
    step(1'b1, 9'h055, 1'b0, 1'b0);
    check_val("t4_ovf",   32'(ovf),   1);
    check_val("t4_count", 32'(count), 8);
    check_val("t4_head",  32'(dout),  9'h011);
    step(1'b0, '0, 1'b0, 1'b1);
    check_val("t4_clr", 32'(ovf), 0);
    step(1'b1, 9'h077, 1'b0, 1'b1);
    check_val("t4_setwins", 32'(ovf), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    check_val("t4_clr2", 32'(ovf), 0);

    // 5: full with simultaneous push+pop
    step(1'b1, 9'h100, 1'b1, 1'b0);
    check_val("t5_count", 32'(count), 8);
    check_val("t5_ovf",   32'(ovf),   0);
    for (int unsigned i = 0; i < 7; i++) begin
      check_val("t5_old", 32'(dout), 9'h012 + i);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check_val("t5_new", 32'(dout), 9'h100);
    step(1'b0, '0, 1'b1, 1'b0);
    check_val("t5_empty", 32'(empty), 1);

    // 6: wrap stress, continuous vin, random rdy, scoreboard with drops
    q.delete();
    m_ovf = 1'b0;
    smp = 9'h000;
    for (int unsigned n = 0; n < 1000; n++) begin
      check_val("t6_count", 32'(count), q.size());
      check_val("t6_vout",  32'(vout),  (q.size() > 0) ? 1 : 0);
      check_val("t6_ovf",   32'(ovf),   32'(m_ovf));
      if (q.size() > 0) check_val("t6_dout", 32'(dout), 32'(q[0]));
      r = 1'($urandom_range(0, 1));
      m_pop  = (q.size() > 0) && r;
      m_push = (q.size() < 8) || m_pop;
      if (!m_push) m_ovf = 1'b1;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(smp);
      step(1'b1, smp, r, 1'b0);
      smp = smp + 9'd1;
    end
    check_val("t6_final_count", 32'(count), q.size());
    check_val("t6_not_both", 32'(full && empty), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
